lfsr_checker: RTL and testbench

- Receive-side companion to the 16-bit LFSR pattern generator.
- Accepts the generator's state stream one word per valid cycle and self-synchronises to it from any nonzero word.
- Declares lock, then counts words that deviate from the predicted sequence.
- Sits at the sink end of the lfsr/flop pattern loop and replaces file-dump checking with on-chip pass/fail status.

---
 rtl/lfsr_checker_if.sv | 11 +
 rtl/lfsr_checker.sv | 121 ++++++++++++
 tb/tb_lfsr_checker.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if: received LFSR word stream.
//   in_valid : in_data carries one generator state this cycle
//   in_data  : received 16-bit LFSR state
// master drives the stream (generator / bench side), slave samples it (checker).
interface lfsr_checker_if;
   logic        in_valid;
   logic [15:0] in_data;

   modport master (output in_valid, output in_data);
   modport slave  (input  in_valid, input  in_data);
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for the 16-bit Fibonacci LFSR
// x^16+x^14+x^13+x^11+1. Self-synchronises from any nonzero word
// (HUNT -> VERIFY -> LOCKED), then counts words deviating from prediction.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   clear      synchronous clear of err_count / word_count (lock unaffected)
//   s          word stream (in_valid, in_data), slave side
//   locked     1 while in LOCKED
//   err_pulse  one-cycle pulse after each mispredicted word while LOCKED
//   err_count  saturating count of mispredicted words while LOCKED
//   word_count valid words checked while LOCKED, wraps
//   expected   current predicted next word
module lfsr_checker #(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int ERR_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   lfsr_checker_if.slave     s,
   output logic              locked,
   output logic              err_pulse,
   output logic [ERR_W-1:0]  err_count,
   output logic [31:0]       word_count,
   output logic [15:0]       expected
);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
   localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   state_t      state;
   logic [3:0]  match_cnt;
   logic [3:0]  miss_cnt;

   logic        hit;
   logic        nonzero;
   logic [3:0]  match_nxt;
   logic [3:0]  miss_nxt;

   assign hit       = (s.in_data == expected);
   assign nonzero   = (s.in_data != 16'h0000);
   assign match_nxt = match_cnt + 4'd1;
   assign miss_nxt  = miss_cnt + 4'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= HUNT;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         err_count  <= '0;
         word_count <= '0;
         expected   <= 16'h0000;
         match_cnt  <= '0;
         miss_cnt   <= '0;
      end else begin
         err_pulse <= 1'b0;
         if (s.in_valid) begin
            case (state)
               HUNT: begin
                  // all-zero is the LFSR lockup state, never a valid seed
                  if (nonzero) begin
                     expected  <= lfsr_next(s.in_data);
                     match_cnt <= '0;
                     state     <= VERIFY;
                  end
               end
               VERIFY: begin
                  if (hit) begin
                     expected  <= lfsr_next(expected);
                     match_cnt <= match_nxt;
                     if (match_nxt == LOCK_N) begin
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        miss_cnt <= '0;
                     end
                  end else if (nonzero) begin
                     // reseed from the new word instead of dropping to HUNT
                     expected  <= lfsr_next(s.in_data);
                     match_cnt <= '0;
                  end else begin
                     state <= HUNT;
                  end
               end
               LOCKED: begin
                  // free-run the prediction so one bad word costs one error
                  expected   <= lfsr_next(expected);
                  word_count <= word_count + 32'd1;
                  if (hit) begin
                     miss_cnt <= '0;
                  end else begin
                     err_pulse <= 1'b1;
                     if (err_count != {ERR_W{1'b1}})
                        err_count <= err_count + ERR_W'(1);
                     miss_cnt <= miss_nxt;
                     if (miss_nxt == LOSS_N) begin
                        state    <= HUNT;
                        locked   <= 1'b0;
                        miss_cnt <= '0;
                     end
                  end
               end
               default: state <= HUNT;
            endcase
         end
         // clear wins over a same-cycle increment
         if (clear) begin
            err_count  <= '0;
            word_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;
   localparam int LOCK_CNT = 4;
   localparam int LOSS_CNT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic        locked, err_pulse, locked2, err_pulse2;
   logic [15:0] err_count, expected, expected2;
   logic [1:0]  err_count2;
   logic [31:0] word_count, word_count2;

   lfsr_checker_if intf ();

   lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(16)) dut (
      .clk(clk), .reset(reset), .clear(clear), .s(intf.slave),
      .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
      .word_count(word_count), .expected(expected));

   lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(2)) dut2 (
      .clk(clk), .reset(reset), .clear(clear), .s(intf.slave),
      .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2),
      .word_count(word_count2), .expected(expected2));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit chk_en = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [15:0] nxt(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   string       m_mode;   // "hunt", "verify", "locked"
   logic [15:0] m_exp;
   int          m_good, m_bad;
   bit          m_pulse;
   int          m_err16, m_err2;
   logic [31:0] m_wc;

   task automatic model_reset();
      m_mode = "hunt"; m_exp = 16'h0; m_good = 0; m_bad = 0;
      m_pulse = 0; m_err16 = 0; m_err2 = 0; m_wc = 0;
   endtask

   task automatic model_step(input bit v, input logic [15:0] d, input bit c);
      m_pulse = 0;
      if (v) begin
         if (m_mode == "hunt") begin
            if (d != 0) begin m_exp = nxt(d); m_good = 0; m_mode = "verify"; end
         end else if (m_mode == "verify") begin
            if (d == m_exp) begin
               m_exp = nxt(m_exp);
               m_good++;
               if (m_good == LOCK_CNT) begin m_mode = "locked"; m_bad = 0; end
            end else if (d != 0) begin
               m_exp = nxt(d); m_good = 0;
            end else m_mode = "hunt";
         end else begin
            m_wc = m_wc + 1;
            if (d == m_exp) m_bad = 0;
            else begin
               m_pulse = 1;
               if (m_err16 < 65535) m_err16++;
               if (m_err2 < 3) m_err2++;
               m_bad++;
               if (m_bad == LOSS_CNT) begin m_mode = "hunt"; m_bad = 0; end
            end
            m_exp = nxt(m_exp);
         end
      end
      if (c) begin m_err16 = 0; m_err2 = 0; m_wc = 0; end
   endtask

   // single compare process, outputs sampled on the falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("locked",      {31'd0, locked},      {31'd0, m_mode == "locked"});
         chk("err_pulse",   {31'd0, err_pulse},   {31'd0, m_pulse});
         chk("err_count",   {16'd0, err_count},   32'(m_err16));
         chk("word_count",  word_count,           m_wc);
         chk("expected",    {16'd0, expected},    {16'd0, m_exp});
         chk("err_count2",  {30'd0, err_count2},  32'(m_err2));
         chk("locked2",     {31'd0, locked2},     {31'd0, m_mode == "locked"});
      end
   end

   // ---------------- stimulus ----------------
   logic [15:0] g;   // generator state: next word the source would send

   task automatic drive(input bit v, input logic [15:0] d, input bit c);
      intf.in_valid = v; intf.in_data = d; clear = c;
      @(posedge clk);
      model_step(v, d, c);
      @(negedge clk);
   endtask

   task automatic good_word();
      drive(1'b1, g, 1'b0);
      g = nxt(g);
   endtask

   task automatic bad_word(input bit c);
      drive(1'b1, ~g, c);
      g = nxt(g);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_locked"},     {31'd0, locked},    32'd0);
      chk({tag, "_err_pulse"},  {31'd0, err_pulse}, 32'd0);
      chk({tag, "_err_count"},  {16'd0, err_count}, 32'd0);
      chk({tag, "_word_count"}, word_count,         32'd0);
      chk({tag, "_expected"},   {16'd0, expected},  32'd0);
   endtask

   task automatic mid_reset(input string tag);
      #2 reset = 1'b0;
      #1 check_reset_vals(tag);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; clear = 1'b0; intf.in_valid = 1'b0; intf.in_data = 16'h0;
      model_reset();
      #1 check_reset_vals("por");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      chk_en = 1;
      drive(1'b0, 16'h0, 1'b0);

      // lock on the stream seeded from abcd
      g = 16'habcd;
      good_word();
      chk("exp_after_seed", {16'd0, expected}, 32'h0000579a);
      repeat (3) good_word();
      chk("not_locked_4", {31'd0, locked}, 32'd0);
      good_word();
      chk("locked_after_5", {31'd0, locked}, 32'd1);
      chk("err0_after_lock", {16'd0, err_count}, 32'd0);

      // single inverted word
      bad_word(1'b0);
      chk("single_pulse", {31'd0, err_pulse}, 32'd1);
      chk("single_err", {16'd0, err_count}, 32'd1);
      good_word();
      chk("pulse_drop", {31'd0, err_pulse}, 32'd0);
      chk("still_locked", {31'd0, locked}, 32'd1);
      repeat (4) good_word();
      chk("no_more_err", {16'd0, err_count}, 32'd1);

      // three consecutive bad words lose lock
      repeat (2) bad_word(1'b0);
      chk("locked_after_2bad", {31'd0, locked}, 32'd1);
      bad_word(1'b0);
      chk("lost_lock", {31'd0, locked}, 32'd0);
      chk("err_after_loss", {16'd0, err_count}, 32'd4);
      repeat (4) good_word();
      chk("relock_not_yet", {31'd0, locked}, 32'd0);
      good_word();
      chk("relock", {31'd0, locked}, 32'd1);

      // zeros in HUNT are ignored
      mid_reset("rst_locked1");
      repeat (10) begin
         drive(1'b1, 16'h0, 1'b0);
         chk("zero_hunt_exp", {16'd0, expected}, 32'd0);
      end
      g = 16'h1234;
      repeat (5) good_word();
      chk("lock_after_zeros", {31'd0, locked}, 32'd1);

      // saturation in the 2-bit counter, then clear against a mismatch
      repeat (5) begin
         bad_word(1'b0);
         repeat (2) good_word();
      end
      chk("sat_err2", {30'd0, err_count2}, 32'd3);
      chk("err16_5", {16'd0, err_count}, 32'd5);
      bad_word(1'b1);
      chk("clear_err", {16'd0, err_count}, 32'd0);
      chk("clear_err2", {30'd0, err_count2}, 32'd0);
      chk("clear_wc", word_count, 32'd0);

      // reset mid-VERIFY and mid-LOCKED
      mid_reset("rst_locked2");
      g = 16'hbeef;
      repeat (3) good_word();
      mid_reset("rst_verify");
      repeat (5) good_word();
      chk("relock_after_rst", {31'd0, locked}, 32'd1);

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         int r;
         bit v, c;
         logic [15:0] d;
         r = $urandom_range(0, 99);
         v = ($urandom_range(0, 99) < 80);
         c = ($urandom_range(0, 99) < 3);
         if (r < 3) g = 16'($urandom_range(1, 65535));
         if (r < 80)      d = g;
         else if (r < 92) d = g ^ 16'($urandom_range(1, 65535));
         else if (r < 96) d = 16'h0;
         else             d = 16'($urandom);
         drive(v, d, c);
         if (v) g = nxt(g);
      end

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
